ex_branch_resolve_stage: RTL

- Sits directly downstream of the 32-bit integer ALU, between EX and MEM.
- Consumes the ALU result and flags with the decoded control bundle, resolves conditional branches and JAL/JALR, and computes the target.
- Buffers the EX/MEM payload in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Issues a one-cycle registered redirect to the fetch stage.

---
 rtl/ex_branch_resolve_stage_if.sv | 50 +++++
 rtl/ex_branch_resolve_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ex_branch_resolve_stage_if.sv
// EX -> branch-resolve -> MEM bundle.
// The master side is the EX/MEM environment. The slave side is the resolve stage.
interface ex_branch_resolve_stage_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            IN_VALID;
  logic            IN_READY;
  logic [XLEN-1:0] ALU_RESULT;
  logic            ZERO_FLAG;
  logic            SLTU_FLAG;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] IMM;
  logic            IS_BRANCH;
  logic            IS_JAL;
  logic            IS_JALR;
  logic [2:0]      FUNCT3;
  logic [RD_W-1:0] RD;
  logic            REG_WE;
  logic            MEM_RD;
  logic            MEM_WR;
  logic [XLEN-1:0] STORE_DATA;
  logic            FLUSH;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] OUT_RESULT;
  logic [XLEN-1:0] OUT_STORE_DATA;
  logic [RD_W-1:0] OUT_RD;
  logic            OUT_REG_WE;
  logic            OUT_MEM_RD;
  logic            OUT_MEM_WR;
  logic [2:0]      OUT_FUNCT3;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            ILLEGAL_BR;

  modport master (
    output IN_VALID, ALU_RESULT, ZERO_FLAG, SLTU_FLAG, PC, IMM, IS_BRANCH, IS_JAL,
           IS_JALR, FUNCT3, RD, REG_WE, MEM_RD, MEM_WR, STORE_DATA, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_RESULT, OUT_STORE_DATA, OUT_RD, OUT_REG_WE,
           OUT_MEM_RD, OUT_MEM_WR, OUT_FUNCT3, REDIRECT, REDIRECT_PC, ILLEGAL_BR
  );

  modport slave (
    input  IN_VALID, ALU_RESULT, ZERO_FLAG, SLTU_FLAG, PC, IMM, IS_BRANCH, IS_JAL,
           IS_JALR, FUNCT3, RD, REG_WE, MEM_RD, MEM_WR, STORE_DATA, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, OUT_RESULT, OUT_STORE_DATA, OUT_RD, OUT_REG_WE,
           OUT_MEM_RD, OUT_MEM_WR, OUT_FUNCT3, REDIRECT, REDIRECT_PC, ILLEGAL_BR
  );
endinterface

// File: rtl/ex_branch_resolve_stage.sv
// Branch/jump resolution after the ALU.
// Includes a 2-entry EX/MEM skid FIFO and a registered one-cycle fetch redirect.
module ex_branch_resolve_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input logic                    CLK,
  input logic                    RESET,
  ex_branch_resolve_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [RD_W-1:0] rd;
    logic            reg_we;
    logic            mem_rd;
    logic            mem_wr;
    logic [2:0]      funct3;
  } entry_t;

  entry_t          mem_q [2];
  entry_t          entry_d;
  entry_t          head;
  logic [1:0]      cnt_q, cnt_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            redir_q, redir_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            ill_q, ill_d;

  logic            in_ready, push, pop, cond, bad_f3, taken, is_jump;
  logic [XLEN-1:0] target, link;

  // The redirect cycle is the wrong-path shadow slot.
  // A beat arriving in it is always swallowed, even when the FIFO is full.
  assign in_ready = (cnt_q != 2'd2) | redir_q;
  assign push     = bus.IN_VALID & in_ready & ~redir_q & ~bus.FLUSH;
  assign pop      = (cnt_q != 2'd0) & bus.OUT_READY;

  // BEQ/BNE see XOR and BLT/BGE see SLT, so both resolve on the zero flag.
  always_comb begin
    cond   = 1'b0;
    bad_f3 = 1'b0;
    case (bus.FUNCT3)
      3'b000:  cond = bus.ZERO_FLAG;
      3'b001:  cond = ~bus.ZERO_FLAG;
      3'b100:  cond = ~bus.ZERO_FLAG;
      3'b101:  cond = bus.ZERO_FLAG;
      3'b110:  cond = bus.SLTU_FLAG;
      3'b111:  cond = ~bus.SLTU_FLAG;
      default: bad_f3 = 1'b1;
    endcase
  end

  assign is_jump = bus.IS_JAL | bus.IS_JALR;
  assign taken   = is_jump | (bus.IS_BRANCH & cond);
  assign target  = bus.IS_JALR ? (bus.ALU_RESULT & {{(XLEN-1){1'b1}}, 1'b0})
                               : (bus.PC + bus.IMM);
  assign link    = bus.PC + XLEN'(4);

  always_comb begin
    entry_d.result     = is_jump ? link : bus.ALU_RESULT;
    entry_d.store_data = bus.STORE_DATA;
    entry_d.rd         = bus.RD;
    entry_d.reg_we     = bus.REG_WE & ~bus.IS_BRANCH;
    entry_d.mem_rd     = bus.MEM_RD;
    entry_d.mem_wr     = bus.MEM_WR;
    entry_d.funct3     = bus.FUNCT3;
  end

  always_comb begin
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    redir_d    = 1'b0;
    redir_pc_d = redir_pc_q;
    ill_d      = 1'b0;
    if (bus.FLUSH) begin
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
      if (push && taken) begin
        redir_d    = 1'b1;
        redir_pc_d = target;
      end
      ill_d = push & bus.IS_BRANCH & bad_f3;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      ill_q      <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      ill_q      <= ill_d;
      if (push) mem_q[wr_ptr_q] <= entry_d;
    end
  end

  assign head               = mem_q[rd_ptr_q];
  assign bus.IN_READY       = in_ready;
  assign bus.OUT_VALID      = (cnt_q != 2'd0);
  assign bus.OUT_RESULT     = head.result;
  assign bus.OUT_STORE_DATA = head.store_data;
  assign bus.OUT_RD         = head.rd;
  assign bus.OUT_REG_WE     = head.reg_we;
  assign bus.OUT_MEM_RD     = head.mem_rd;
  assign bus.OUT_MEM_WR     = head.mem_wr;
  assign bus.OUT_FUNCT3     = head.funct3;
  assign bus.REDIRECT       = redir_q;
  assign bus.REDIRECT_PC    = redir_pc_q;
  assign bus.ILLEGAL_BR     = ill_q;

endmodule
